// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the fetch PC, issues sequential requests to a variable-latency
// instruction memory, and buffers in-order responses for decode in a small FIFO.
module instr_fetch_queue #(
  parameter int                  PC_WIDTH          = 9,
  parameter int                  INSTRUCTION_WIDTH = 32,
  parameter int                  DEPTH             = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC          = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            Redirect,
  input  logic [PC_WIDTH-1:0]             RedirectPC,
  input  logic                            Stall,
  output logic                            ImemReqValid,
  output logic [PC_WIDTH-1:0]             ImemReqAddr,
  input  logic                            ImemReqReady,
  input  logic                            ImemRspValid,
  input  logic [INSTRUCTION_WIDTH-1:0]    ImemRspData,
  output logic                            InstrValid,
  output logic [PC_WIDTH-1:0]             InstrPC,
  output logic [INSTRUCTION_WIDTH-1:0]    Instr,
  output logic [$clog2(DEPTH+1)-1:0]      Count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;
  localparam int PTR_W = $clog2(DEPTH);

  logic [PC_WIDTH-1:0]          fetch_pc;
  logic [PC_WIDTH-1:0]          rsp_pc;
  logic [PTR_W-1:0]             rd_ptr;
  logic [PTR_W-1:0]             wr_ptr;
  logic [CNT_W-1:0]             count;
  logic [CNT_W-1:0]             outstanding;
  logic [CNT_W-1:0]             drop_cnt;
  logic [PC_WIDTH-1:0]          fifo_pc_p1    [DEPTH];
  logic [INSTRUCTION_WIDTH-1:0] fifo_instr_p1 [DEPTH];

  logic [SUM_W-1:0] credit_sum;
  logic             accept;
  logic             drop;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] outstanding_nxt;

  // Credit covers both buffered entries and requests still in flight, so every
  // response that returns is guaranteed a FIFO slot.
  assign credit_sum      = SUM_W'(outstanding) + SUM_W'(count);
  assign ImemReqValid    = (credit_sum < SUM_W'(DEPTH));
  assign accept          = ImemReqValid && ImemReqReady;
  assign drop            = ImemRspValid && (drop_cnt != '0);
  assign push            = ImemRspValid && !drop && !Redirect;
  assign pop             = InstrValid && !Stall && !Redirect;
  assign outstanding_nxt = outstanding + CNT_W'(accept) - CNT_W'(ImemRspValid);

  // Stage p0 -> p1: request/response bookkeeping and FIFO control
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (Redirect) begin
        // Everything still pending, including this cycle's accept, returns stale.
        fetch_pc <= RedirectPC;
        rsp_pc   <= RedirectPC;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        drop_cnt <= outstanding_nxt;
      end else begin
        if (accept) fetch_pc <= fetch_pc + PC_WIDTH'(4);
        if (drop)   drop_cnt <= drop_cnt - CNT_W'(1);
        if (push) begin
          rsp_pc <= rsp_pc + PC_WIDTH'(4);
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Stage p1: FIFO storage (data path, not reset)
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_p1[wr_ptr]    <= rsp_pc;
      fifo_instr_p1[wr_ptr] <= ImemRspData;
    end
  end

  assign ImemReqAddr = fetch_pc;
  assign InstrValid  = (count != '0);
  assign InstrPC     = fifo_pc_p1[rd_ptr];
  assign Instr       = fifo_instr_p1[rd_ptr];
  assign Count       = count;

endmodule
